avgpool_feeder: RTL and testbench
=================================

AVGPOOL_FEEDER -- requirements
Module: avgpool_feeder

Interface
REQ-001 Parameter PIX_W, default 10, width of one pixel in bits.
REQ-002 Parameter LANES, default 9, pixels packed per output word.
REQ-003 Parameter N_PIX, default 4096, pixels per channel; legal range 1..65535.
REQ-004 Port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port i_reset  input  1  asynchronous, active-low reset.
REQ-006 Port i_start  input  1  one-cycle request to begin one channel.
REQ-007 Port i_data  input  PIX_W  pixel value, unsigned.
REQ-008 Port i_valid  input  1  i_data is valid this cycle.
REQ-009 Port o_ready  output  1  block accepts a pixel this cycle.
REQ-010 Port o_data  output  PIX_W*LANES  packed pixel word; lane k in bits [k*PIX_W +: PIX_W].
REQ-011 Port o_writeAdd  output  1  one-cycle strobe: o_data valid for the downstream accumulator.
REQ-012 Port o_accReset  output  1  active-low clear for the downstream accumulator.
REQ-013 Port o_busy  output  1  high in every state except IDLE.
REQ-014 Port o_done  output  1  one-cycle pulse when a channel is complete.

Function
REQ-015 The FSM SHALL have states IDLE, CLEAR, FILL, FLUSH and DONE.
REQ-016 In IDLE, i_start=1 SHALL move the FSM to CLEAR; i_start SHALL be ignored in all other states.
REQ-017 In CLEAR, for exactly one cycle, o_accReset SHALL be 0; the FSM then enters FILL. o_accReset SHALL be 1 in all other states.
REQ-018 o_ready SHALL be 1 only in FILL; a pixel is accepted when i_valid & o_ready.
REQ-019 Accepted pixels SHALL fill lanes in order from lane 0 to lane LANES-1.
REQ-020 The lane index SHALL wrap from LANES-1 to 0.
REQ-021 One cycle after the handshake that fills lane LANES-1, o_data SHALL hold the packed word and o_writeAdd SHALL be 1 for that single cycle.
REQ-022 The fill buffer and the output register SHALL be separate, so FILL never stalls. Back-to-back pixels SHALL produce one o_writeAdd every LANES accepted pixels.
REQ-023 A 16-bit pixel counter SHALL count accepted pixels per channel.
REQ-024 On the handshake of pixel N_PIX, if the lane index is nonzero, the FSM SHALL enter FLUSH.
REQ-025 FLUSH SHALL emit the partial word with unfilled lanes forced to 0 and o_writeAdd=1 for one cycle, then enter DONE.
REQ-026 On the handshake of pixel N_PIX, if the lane index is 0 (exact multiple of LANES), the FSM SHALL enter DONE directly after the normal emit of REQ-021.
REQ-027 DONE SHALL last one cycle with o_done=1, then return to IDLE.
REQ-028 o_data SHALL hold its last emitted value while o_writeAdd=0.
REQ-029 o_writeAdd SHALL never assert outside FILL, FLUSH and the first cycle of DONE; the total lanes summed downstream per channel SHALL equal N_PIX.

Reset
REQ-030 i_reset=0 SHALL immediately force the FSM to IDLE.
REQ-031 i_reset=0 SHALL clear the counters, the lane buffer and o_data to 0.
REQ-032 During reset, o_writeAdd, o_done, o_ready and o_busy SHALL be 0, and o_accReset SHALL be 1.
REQ-033 A reset mid-channel SHALL discard the partial word without emitting it.

Configuration
REQ-034 With FEEDER_STALL_CNT_EN defined, the block SHALL add output o_stallCnt[15:0]: a saturating count of FILL cycles with i_valid=0, cleared in CLEAR and by reset.
REQ-035 Without FEEDER_STALL_CNT_EN, neither the port nor the counter SHALL exist.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding and the defaults for PIX_W, LANES and N_PIX.
REQ-037 The lane packer (lane buffer, lane index and zero-fill) SHALL be one sub-module, avgpool_lane_pack.

Verification
REQ-038 Reset, then i_start with 4096 pixels all equal to 5 → 456 o_writeAdd strobes; the final word is 5 in lane 0 and zeros elsewhere; o_done fires once; the downstream sum is 20480.
REQ-039 N_PIX=18 with pixels 1..18 back-to-back → two strobes: lanes 1..9, then lanes 10..18; no FLUSH; o_done 1 cycle after the second strobe.
REQ-040 N_PIX=10 with i_valid toggling 1/0 → one full strobe, then a FLUSH word with 10 in lane 0; with FEEDER_STALL_CNT_EN, o_stallCnt equals the number of idle FILL cycles.
REQ-041 i_start pulsed during FILL → ignored; the pixel count and lane order are unchanged.
REQ-042 i_reset driven low after 7 pixels → no strobe, IDLE, o_busy=0; a new i_start gives a clean o_accReset=0 pulse.

Source files
------------

// File: rtl/avgpool_feeder_pkg.sv
`timescale 1ns/1ps
// avgpool_feeder_pkg: shared FSM state encoding and parameter defaults for the feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state_t (IDLE/CLEAR/FILL/FLUSH/DONE), PIX_W/LANES/N_PIX defaults, lane index width helper.
package avgpool_feeder_pkg;

  localparam int PIX_W_DEF = 10;
  localparam int LANES_DEF = 9;
  localparam int N_PIX_DEF = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FILL,
    ST_FLUSH,
    ST_DONE
  } state_t;

  // Width of a lane index; at least one bit so LANES=1 still elaborates.
  function automatic int lane_idx_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/avgpool_lane_pack.sv
`timescale 1ns/1ps
// avgpool_lane_pack: packs pixels into LANES-wide words, emits full or final partial words.
// Latency: word and o_emit appear one cycle after the pushing handshake.
// Backpressure: none; separate fill buffer and output register let pushes continue every cycle.
// Ports: i_clk, i_reset (async active-low), i_clear (sync restart), i_push/i_last/i_pix (pixel in),
//        o_word/o_emit (registered word + strobe), o_word_full (current push fills the last lane).
module avgpool_lane_pack
  import avgpool_feeder_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int LANES = LANES_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_clear,
  input  logic                   i_push,
  input  logic                   i_last,
  input  logic [PIX_W-1:0]       i_pix,
  output logic [PIX_W*LANES-1:0] o_word,
  output logic                   o_emit,
  output logic                   o_word_full
);

  localparam int LIDX_W = lane_idx_w(LANES);

  logic [PIX_W*LANES-1:0] r_buf;
  logic [PIX_W*LANES-1:0] w_merged;
  logic [LIDX_W-1:0]      r_idx;
  logic                   w_full;

  assign w_full      = (r_idx == LIDX_W'(LANES - 1));
  assign o_word_full = w_full;

  // Buffer contents with the incoming pixel dropped into the current lane.
  always_comb begin
    w_merged = r_buf;
    w_merged[int'(r_idx)*PIX_W +: PIX_W] = i_pix;
  end

  // The buffer is zeroed after every emit and on clear, so lanes beyond the
  // fill point of a final partial word are already zero when it is emitted.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_buf  <= '0;
      r_idx  <= '0;
      o_word <= '0;
      o_emit <= 1'b0;
    end else begin
      o_emit <= 1'b0;
      if (i_clear) begin
        r_buf <= '0;
        r_idx <= '0;
      end else if (i_push) begin
        if (w_full || i_last) begin
          o_word <= w_merged;
          o_emit <= 1'b1;
          r_buf  <= '0;
          r_idx  <= '0;
        end else begin
          r_buf <= w_merged;
          r_idx <= r_idx + LIDX_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/avgpool_feeder.sv
`timescale 1ns/1ps
// avgpool_feeder: streams N_PIX pixels of one channel into LANES-wide words for an accumulator.
// Latency: each word strobes one cycle after the handshake that completes it; o_done follows the last strobe.
// Backpressure: o_ready only in FILL while pixels remain; no internal stall once filling.
// Ports: i_clk, i_reset (async active-low), i_start, i_data/i_valid/o_ready (pixel stream),
//        o_data/o_writeAdd (word + strobe), o_accReset (active-low accumulator clear), o_busy, o_done.
// Option: define FEEDER_STALL_CNT_EN to add o_stallCnt[15:0], saturating count of idle FILL cycles.
module avgpool_feeder
  import avgpool_feeder_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int LANES = LANES_DEF,
  parameter int N_PIX = N_PIX_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [PIX_W-1:0]       i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [PIX_W*LANES-1:0] o_data,
  output logic                   o_writeAdd,
  output logic                   o_accReset,
  output logic                   o_busy,
  output logic                   o_done
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]            o_stallCnt
`endif
);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_pix_cnt;
  logic        w_push;
  logic        w_last;
  logic        w_cnt_full;
  logic        w_clear;
  logic        w_word_full;

  assign w_push     = i_valid & o_ready;
  assign w_last     = (r_pix_cnt == 16'(N_PIX - 1));
  assign w_cnt_full = (r_pix_cnt == 16'(N_PIX));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // After an exact-multiple final pixel the FSM lingers one cycle in FILL
  // (not ready) so DONE follows the word strobe instead of overlapping it.
  always_comb begin
    w_next     = r_state;
    o_ready    = 1'b0;
    o_busy     = 1'b1;
    o_done     = 1'b0;
    o_accReset = 1'b1;
    w_clear    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start) w_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        o_accReset = 1'b0;
        w_clear    = 1'b1;
        w_next     = ST_FILL;
      end
      ST_FILL: begin
        o_ready = !w_cnt_full;
        if (w_cnt_full)                           w_next = ST_DONE;
        else if (w_push && w_last && !w_word_full) w_next = ST_FLUSH;
      end
      ST_FLUSH: w_next = ST_DONE;
      ST_DONE: begin
        o_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)     r_pix_cnt <= '0;
    else if (w_clear) r_pix_cnt <= '0;
    else if (w_push)  r_pix_cnt <= r_pix_cnt + 16'd1;
  end

  avgpool_lane_pack #(
    .PIX_W (PIX_W),
    .LANES (LANES)
  ) u_pack (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clear     (w_clear),
    .i_push      (w_push),
    .i_last      (w_last),
    .i_pix       (i_data),
    .o_word      (o_data),
    .o_emit      (o_writeAdd),
    .o_word_full (w_word_full)
  );

`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Counts only cycles where a pixel was wanted but not offered.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)                                    r_stall_cnt <= '0;
    else if (w_clear)                                r_stall_cnt <= '0;
    else if (o_ready && !i_valid && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign o_stallCnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_avgpool_feeder.sv
`timescale 1ns/1ps
module tb_avgpool_feeder;
  import avgpool_feeder_pkg::*;

  localparam int PW = 10;
  localparam int L  = 9;
  localparam int W  = PW * L;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_valid;
  logic [PW-1:0] i_data;
  logic [2:0]    i_start;
  logic [2:0]    rdy, wr, accr, busy, done;
  logic [W-1:0]  od [3];
`ifdef FEEDER_STALL_CNT_EN
  logic [15:0]   stc [3];
`endif

  always #5 clk = ~clk;

  // Three instances: default 4096 pixels, 18 pixels (exact multiple), 10 pixels (partial tail).
  avgpool_feeder #(.PIX_W(PW), .LANES(L), .N_PIX(4096)) u_big (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start[0]), .i_data(i_data), .i_valid(i_valid),
    .o_ready(rdy[0]), .o_data(od[0]), .o_writeAdd(wr[0]), .o_accReset(accr[0]),
    .o_busy(busy[0]), .o_done(done[0])
`ifdef FEEDER_STALL_CNT_EN
    , .o_stallCnt(stc[0])
`endif
  );
  avgpool_feeder #(.PIX_W(PW), .LANES(L), .N_PIX(18)) u_n18 (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start[1]), .i_data(i_data), .i_valid(i_valid),
    .o_ready(rdy[1]), .o_data(od[1]), .o_writeAdd(wr[1]), .o_accReset(accr[1]),
    .o_busy(busy[1]), .o_done(done[1])
`ifdef FEEDER_STALL_CNT_EN
    , .o_stallCnt(stc[1])
`endif
  );
  avgpool_feeder #(.PIX_W(PW), .LANES(L), .N_PIX(10)) u_n10 (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start[2]), .i_data(i_data), .i_valid(i_valid),
    .o_ready(rdy[2]), .o_data(od[2]), .o_writeAdd(wr[2]), .o_accReset(accr[2]),
    .o_busy(busy[2]), .o_done(done[2])
`ifdef FEEDER_STALL_CNT_EN
    , .o_stallCnt(stc[2])
`endif
  );

  int           checks = 0;
  int           failures = 0;
  int           cyc_g = 0;
  int           sel = 0;
  bit           mon_en = 1'b0;
  bit           timed_out;
  int           px[$];
  logic [W-1:0] got_q[$];
  int           got_cyc[$];
  int           n_done, done_cyc, n_accr, n_stall, n_stray, last_hs;

  always @(posedge clk) cyc_g <= cyc_g + 1;

  // Monitor: records strobes, done pulses, accumulator clears and idle-ready cycles.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) if (k != sel && wr[k]) n_stray++;
      if (wr[sel]) begin
        got_q.push_back(od[sel]);
        got_cyc.push_back(cyc_g);
      end
      if (done[sel]) begin
        n_done++;
        done_cyc = cyc_g;
      end
      if (!accr[sel]) n_accr++;
      if (rdy[sel] && !i_valid) n_stall++;
    end
  end

  // Reference: word w holds pixels w*L .. w*L+L-1, lanes past the channel end are zero.
  function automatic logic [W-1:0] exp_word(input int w, input int npix);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < L; k++)
      if (w * L + k < npix) r[k*PW +: PW] = PW'(px[w*L+k]);
    return r;
  endfunction

  // Number of words that differ from the reference, or -1 on a count mismatch.
  function automatic int bad_words(input int npix);
    int nw;
    int bad;
    nw  = (npix + L - 1) / L;
    bad = 0;
    if (got_q.size() != nw) return -1;
    for (int w = 0; w < nw; w++) if (got_q[w] !== exp_word(w, npix)) bad++;
    return bad;
  endfunction

  task automatic clear_mon();
    got_q.delete();
    got_cyc.delete();
    n_done = 0; done_cyc = -1; n_accr = 0; n_stall = 0; last_hs = -1;
  endtask

  // vmode: 0 back-to-back, 1 toggling valid, 2 random valid.
  task automatic run_channel(input int s, input int npix, input int vmode,
                             input bit start_mid, input int stop_at);
    int idx;
    int cyc;
    int limit;
    idx = 0; cyc = 0; limit = npix * 4 + 50;
    sel = s; clear_mon(); mon_en = 1'b1; timed_out = 1'b0;
    @(posedge clk); #1 i_start[s] = 1'b1;
    @(posedge clk); #1 i_start[s] = 1'b0;
    while (n_done == 0 && cyc < limit && !(stop_at < npix && idx >= stop_at)) begin
      i_valid = (idx < npix) && (vmode == 0 || (vmode == 1 && cyc % 2 == 0) ||
                                 (vmode == 2 && $urandom_range(0, 1) == 1));
      i_data = (idx < npix) ? PW'(px[idx]) : '0;
      i_start[s] = start_mid && (cyc == 5);
      @(negedge clk);
      if (i_valid && rdy[s]) begin
        idx++;
        last_hs = cyc_g;
      end
      @(posedge clk); #1;
      cyc++;
    end
    i_valid = 1'b0;
    i_start[s] = 1'b0;
    if (cyc >= limit) timed_out = 1'b1;
    if (stop_at >= npix) begin
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  task automatic fill_rand(input int n);
    px.delete();
    for (int i = 0; i < n; i++) px.push_back(int'($urandom_range(0, 1023)));
  endtask

  task automatic test_reset();
    i_reset = 1'b0; i_valid = 1'b0; i_data = '0; i_start = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({wr, done, rdy, busy} !== 12'd0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0", {wr, done, rdy, busy});
    end
    checks++;
    if (accr !== 3'b111) begin
      failures++;
      $display("FAIL reset_accreset got=%b exp=111", accr);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (od[k] !== '0) begin
        failures++;
        $display("FAIL reset_odata inst=%0d got=%h exp=0", k, od[k]);
      end
    end
    @(posedge clk); #1 i_reset = 1'b1;
  endtask

  task automatic test_full_channel();
    int sum;
    px.delete();
    for (int i = 0; i < 4096; i++) px.push_back(5);
    run_channel(0, 4096, 0, 1'b0, 4096);
    checks++;
    if (timed_out) begin failures++; $display("FAIL big_timeout got=timeout exp=done"); end
    checks++;
    if (got_q.size() != 456) begin
      failures++;
      $display("FAIL big_strobes got=%0d exp=456", got_q.size());
    end
    checks++;
    if (got_q.size() > 0 && got_q[got_q.size()-1] !== W'(5)) begin
      failures++;
      $display("FAIL big_last_word got=%h exp=%h", got_q[got_q.size()-1], W'(5));
    end
    sum = 0;
    foreach (got_q[i]) for (int k = 0; k < L; k++) sum += int'(got_q[i][k*PW +: PW]);
    checks++;
    if (sum != 20480) begin failures++; $display("FAIL big_sum got=%0d exp=20480", sum); end
    checks++;
    if (n_done != 1 || n_accr != 1) begin
      failures++;
      $display("FAIL big_done_accr got=%0d/%0d exp=1/1", n_done, n_accr);
    end
    checks++;
    if (busy[0] !== 1'b0) begin failures++; $display("FAIL big_idle got=%b exp=0", busy[0]); end
  endtask

  task automatic test_exact_multiple();
    int b;
    px.delete();
    for (int i = 1; i <= 18; i++) px.push_back(i);
    run_channel(1, 18, 0, 1'b0, 18);
    b = bad_words(18);
    checks++;
    if (b != 0) begin failures++; $display("FAIL n18_words got=%0d bad exp=0", b); end
    checks++;
    if (got_cyc.size() != 2 || got_cyc[1] != got_cyc[0] + 9 || got_cyc[1] != last_hs + 1) begin
      failures++;
      $display("FAIL n18_strobe_timing got=%0d exp=%0d", (got_cyc.size() > 1) ? got_cyc[1] : -1, last_hs + 1);
    end
    checks++;
    if (n_done != 1 || done_cyc != last_hs + 2) begin
      failures++;
      $display("FAIL n18_done_timing got=%0d/%0d exp=1/%0d", n_done, done_cyc, last_hs + 2);
    end
  endtask

  task automatic test_toggle_flush();
    int b;
    px.delete();
    for (int i = 1; i <= 10; i++) px.push_back(i);
    run_channel(2, 10, 1, 1'b0, 10);
    b = bad_words(10);
    checks++;
    if (b != 0) begin failures++; $display("FAIL n10_words got=%0d bad exp=0", b); end
    checks++;
    if (got_q.size() == 2 && got_q[1] !== W'(10)) begin
      failures++;
      $display("FAIL n10_flush_word got=%h exp=%h", got_q[1], W'(10));
    end
    checks++;
    if (n_done != 1 || done_cyc != last_hs + 2) begin
      failures++;
      $display("FAIL n10_done_timing got=%0d/%0d exp=1/%0d", n_done, done_cyc, last_hs + 2);
    end
`ifdef FEEDER_STALL_CNT_EN
    checks++;
    if (stc[2] !== 16'(n_stall)) begin
      failures++;
      $display("FAIL n10_stallcnt got=%0d exp=%0d", stc[2], n_stall);
    end
`endif
  endtask

  task automatic test_start_ignored();
    int b;
    fill_rand(18);
    run_channel(1, 18, 2, 1'b1, 18);
    b = bad_words(18);
    checks++;
    if (b != 0) begin failures++; $display("FAIL midstart_words got=%0d bad exp=0", b); end
    checks++;
    if (n_done != 1 || n_accr != 1) begin
      failures++;
      $display("FAIL midstart_done_accr got=%0d/%0d exp=1/1", n_done, n_accr);
    end
  endtask

  task automatic test_reset_mid();
    int b;
    fill_rand(18);
    run_channel(1, 18, 0, 1'b0, 7);
    i_reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy[1] !== 1'b0 || rdy[1] !== 1'b0 || od[1] !== '0) begin
      failures++;
      $display("FAIL rstmid_state got=%b%b/%h exp=00/0", busy[1], rdy[1], od[1]);
    end
    repeat (2) @(posedge clk);
    #1 i_reset = 1'b1;
    repeat (2) @(posedge clk);
    checks++;
    if (got_q.size() != 0) begin
      failures++;
      $display("FAIL rstmid_strobe got=%0d exp=0", got_q.size());
    end
    fill_rand(18);
    run_channel(1, 18, 0, 1'b0, 18);
    b = bad_words(18);
    checks++;
    if (b != 0 || n_accr != 1 || n_done != 1) begin
      failures++;
      $display("FAIL rstmid_restart got=%0d/%0d/%0d exp=0/1/1", b, n_accr, n_done);
    end
  endtask

  task automatic test_back_to_back();
    int b;
    for (int r = 0; r < 3; r++) begin
      fill_rand(10);
      run_channel(2, 10, 2, 1'b0, 10);
      b = bad_words(10);
      checks++;
      if (b != 0 || n_done != 1 || timed_out) begin
        failures++;
        $display("FAIL b2b_run%0d got=%0d/%0d exp=0/1", r, b, n_done);
      end
    end
    checks++;
    if (n_stray != 0) begin failures++; $display("FAIL stray_strobes got=%0d exp=0", n_stray); end
  endtask

  initial begin
    n_stray = 0;
    clear_mon();
    i_reset = 1'b0; i_valid = 1'b0; i_data = '0; i_start = '0;
    test_reset();
    test_full_channel();
    test_exact_multiple();
    test_toggle_flush();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
